iob_clint_timer: RTL
====================

IOB_CLINT_TIMER -- requirements
Module: iob_clint_timer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning CPU data width (only 32 supported).
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning byte-address width of the register window.
REQ-003 The block SHALL have parameter N_HARTS, default 1, range 1..8, meaning the number of msip/mtimecmp/interrupt sets.
REQ-004 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: valid  input  1  CPU request strobe.
REQ-007 Port: address  input  ADDR_W  byte address.
REQ-008 Port: wdata  input  DATA_W  write data.
REQ-009 Port: wstrb  input  DATA_W/8  byte enables; all-zero means read.
REQ-010 Port: rdata  output  DATA_W  read data.
REQ-011 Port: ready  output  1  request-complete pulse.
REQ-012 Port: rtc_tick  input  1  single-cycle, clk-synchronous timebase pulse.
REQ-013 Port: mtip  output  N_HARTS  machine timer interrupt, one bit per hart.
REQ-014 Port: msip  output  N_HARTS  machine software interrupt, one bit per hart.

Function
REQ-015 Register map: MSIP[h] at 0x0000+4h (bit 0 only); MTIMECMP[h] LO/HI at 0x4000+8h / 0x4004+8h; MTIME LO/HI at 0xBFF8 / 0xBFFC.
REQ-016 ready SHALL pulse high exactly one cycle after each cycle valid is high; rdata SHALL be valid and stable while ready is high, else 0.
REQ-017 Writes SHALL honour wstrb per byte; MSIP bits 31:1 SHALL read 0 and ignore writes.
REQ-018 Unmapped addresses and hart indices >= N_HARTS: reads SHALL return 0, writes SHALL have no effect, ready SHALL still pulse.
REQ-019 mtime (64-bit) SHALL increment by 1 on each clk edge where rtc_tick=1; 0xFFFF_FFFF_FFFF_FFFF SHALL wrap to 0.
REQ-020 A CPU write to MTIME LO/HI in the same cycle as rtc_tick SHALL take priority: written bytes take wdata, unwritten bytes keep the pre-increment value, no increment that cycle.
REQ-021 mtip[h] SHALL be registered, equal to (mtime >= mtimecmp[h]) unsigned 64-bit, one cycle after the operands change.
REQ-022 msip[h] SHALL equal MSIP[h] bit 0 directly from the register.
REQ-023 A 64-bit compare register updated in two 32-bit halves MAY produce a transient mtip; software sequencing is outside scope.

Reset
REQ-024 On rst_n low, asynchronously: mtime=0, every mtimecmp=0xFFFF_FFFF_FFFF_FFFF, every MSIP=0, mtip=0, msip=0, ready=0, rdata=0.
REQ-025 A request in flight when rst_n asserts SHALL be dropped; no ready pulse after reset release for it.
REQ-026 The first request SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-027 Macro CLINT_MTIME_LATCH_EN: when defined, reading MTIME LO SHALL snapshot mtime[63:32] into a shadow register, and reading MTIME HI SHALL return the shadow (reset 0).
REQ-028 Without CLINT_MTIME_LATCH_EN, MTIME HI SHALL return live mtime[63:32] and no shadow register SHALL exist.

Verification
REQ-029 Reset, read 0xBFF8 -> rdata 0, ready one cycle later; mtip=0 with mtimecmp all-ones.
REQ-030 Write MTIMECMP[0]=0x5 (LO=5, HI=0), apply 5 rtc_tick pulses -> mtip[0] rises one cycle after mtime reaches 5.
REQ-031 Write MTIME=0xFFFF_FFFF_FFFF_FFFF, one tick -> mtime reads 0, mtip[0] clears when mtimecmp=5.
REQ-032 Write MTIME LO=0x1234 with wstrb=0x3 coincident with rtc_tick -> mtime LO reads 0x0000_1234 exactly, no increment.
REQ-033 Write 0xFFFF_FFFF to MSIP[0] -> msip[0]=1, readback 0x1; write to 0x0020 with N_HARTS=1 -> no effect, reads 0.
REQ-034 With CLINT_MTIME_LATCH_EN, mtime=0x0000_0000_FFFF_FFFF, read LO, tick, read HI -> HI reads 0; without macro -> HI reads 1.

Source files
------------

// File: rtl/iob_clint_timer_if.sv
// CPU register-bus bundle for the CLINT timer: valid/address/wdata/wstrb request
// with a single-cycle ready/rdata response.
interface iob_clint_timer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) ();
    logic                  valid;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;

    modport master (
        output valid, address, wdata, wstrb,
        input  rdata, ready
    );

    modport slave (
        input  valid, address, wdata, wstrb,
        output rdata, ready
    );
endinterface

// File: rtl/iob_clint_timer.sv
// RISC-V CLINT timer: 64-bit mtime, per-hart mtimecmp/msip and registered mtip.
// Optional feature macro: CLINT_MTIME_LATCH_EN (MTIME HI reads a shadow taken on MTIME LO reads).
module iob_clint_timer #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int N_HARTS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    iob_clint_timer_if.slave    bus,
    input  logic                rtc_tick,
    output logic [N_HARTS-1:0]  mtip,
    output logic [N_HARTS-1:0]  msip
);

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] result;
        result = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                result[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return result;
    endfunction

    logic                wr_en;
    logic                rd_en;
    logic                mtime_lo_sel;
    logic                mtime_hi_sel;
    logic [N_HARTS-1:0]  msip_sel;
    logic [N_HARTS-1:0]  cmp_lo_sel;
    logic [N_HARTS-1:0]  cmp_hi_sel;
    logic [63:0]         cmp_val [N_HARTS];

    logic [63:0]         mtime_reg;
    logic [63:0]         mtime_next;
    logic [31:0]         mtime_hi_rd;
    logic [DATA_W-1:0]   rdata_reg;
    logic [DATA_W-1:0]   rdata_next;
    logic                ready_reg;

    assign wr_en        = bus.valid && (bus.wstrb != '0);
    assign rd_en        = bus.valid && (bus.wstrb == '0);
    assign mtime_lo_sel = (bus.address == ADDR_W'(16'hBFF8));
    assign mtime_hi_sel = (bus.address == ADDR_W'(16'hBFFC));

    // Per-hart decode and state; only harts that exist get address matches.
    generate
        for (genvar gi = 0; gi < N_HARTS; gi++) begin : g_hart
            logic [63:0] cmp_reg;
            logic        msip_bit_reg;
            logic        mtip_bit_reg;

            assign msip_sel[gi]   = (bus.address == ADDR_W'(4 * gi));
            assign cmp_lo_sel[gi] = (bus.address == ADDR_W'(32'h4000 + 8 * gi));
            assign cmp_hi_sel[gi] = (bus.address == ADDR_W'(32'h4004 + 8 * gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cmp_reg      <= '1;
                    msip_bit_reg <= 1'b0;
                    mtip_bit_reg <= 1'b0;
                end else begin
                    if (wr_en && cmp_lo_sel[gi]) begin
                        cmp_reg[31:0] <= merge_bytes(cmp_reg[31:0], bus.wdata, bus.wstrb);
                    end
                    if (wr_en && cmp_hi_sel[gi]) begin
                        cmp_reg[63:32] <= merge_bytes(cmp_reg[63:32], bus.wdata, bus.wstrb);
                    end
                    if (wr_en && msip_sel[gi] && bus.wstrb[0]) begin
                        msip_bit_reg <= bus.wdata[0];
                    end
                    // Compares the current register values, so mtip trails operand changes by one cycle.
                    mtip_bit_reg <= (mtime_reg >= cmp_reg);
                end
            end

            assign cmp_val[gi] = cmp_reg;
            assign msip[gi]    = msip_bit_reg;
            assign mtip[gi]    = mtip_bit_reg;
        end
    endgenerate

    // A CPU write to either mtime half wins over the tick; the other half is left untouched.
    always_comb begin
        mtime_next = mtime_reg;
        if (wr_en && mtime_lo_sel) begin
            mtime_next[31:0] = merge_bytes(mtime_reg[31:0], bus.wdata, bus.wstrb);
        end else if (wr_en && mtime_hi_sel) begin
            mtime_next[63:32] = merge_bytes(mtime_reg[63:32], bus.wdata, bus.wstrb);
        end else if (rtc_tick) begin
            mtime_next = mtime_reg + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_reg <= '0;
        end else begin
            mtime_reg <= mtime_next;
        end
    end

`ifdef CLINT_MTIME_LATCH_EN
    logic [31:0] mtime_hi_shadow_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_hi_shadow_reg <= '0;
        end else if (rd_en && mtime_lo_sel) begin
            mtime_hi_shadow_reg <= mtime_reg[63:32];
        end
    end

    assign mtime_hi_rd = mtime_hi_shadow_reg;
`else
    assign mtime_hi_rd = mtime_reg[63:32];
`endif

    always_comb begin
        rdata_next = '0;
        if (mtime_lo_sel) begin
            rdata_next = mtime_reg[31:0];
        end
        if (mtime_hi_sel) begin
            rdata_next = mtime_hi_rd;
        end
        for (int h = 0; h < N_HARTS; h++) begin
            if (msip_sel[h]) begin
                rdata_next = {31'b0, msip[h]};
            end
            if (cmp_lo_sel[h]) begin
                rdata_next = cmp_val[h][31:0];
            end
            if (cmp_hi_sel[h]) begin
                rdata_next = cmp_val[h][63:32];
            end
        end
    end

    // Response register: rdata is forced to zero whenever ready is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_reg <= 1'b0;
            rdata_reg <= '0;
        end else begin
            ready_reg <= bus.valid;
            rdata_reg <= bus.valid ? rdata_next : '0;
        end
    end

    assign bus.ready = ready_reg;
    assign bus.rdata = rdata_reg;

endmodule
